// File: rtl/thread_scheduler.sv
// Thread scheduler: slot table plus pending-spawn FIFO, with promote-first then round-robin grant.
// Optional statistics counters are enabled by defining THRD_SCHED_STATS_EN.
module thread_scheduler #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MAX_THREADS = 8,
  parameter int unsigned IDX_W       = $clog2(MAX_THREADS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sched_req,
  output logic              sched_busy,
  output logic              sched_vld,
  output logic              sched_none,
  output logic [IDX_W-1:0]  sched_id,
  output logic [DATA_W-1:0] sched_addr,
  input  logic              spawn_vld,
  input  logic [DATA_W-1:0] spawn_addr,
  output logic              spawn_ack,
  output logic              spawn_ok,
  input  logic              done_vld,
  input  logic [IDX_W-1:0]  done_id,
  output logic [IDX_W:0]    active_cnt,
  output logic [IDX_W:0]    pend_cnt,
  output logic              idle
`ifdef THRD_SCHED_STATS_EN
  ,
  output logic [31:0]       grant_cnt,
  output logic [15:0]       spawn_drop_cnt
`endif
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_GRANT} state_t;

  state_t                  r_state;
  logic [MAX_THREADS-1:0]  r_valid;
  logic [DATA_W-1:0]       r_slot_addr [MAX_THREADS];
  logic [DATA_W-1:0]       r_fifo      [MAX_THREADS];
  logic [IDX_W-1:0]        r_rd_ptr;
  logic [IDX_W-1:0]        r_wr_ptr;
  logic [CNT_W-1:0]        r_pend_cnt;
  logic [CNT_W-1:0]        r_active_cnt;
  logic                    r_idle;
  logic [IDX_W-1:0]        r_last;
  logic                    r_busy;
  logic                    r_sched_vld;
  logic                    r_sched_none;
  logic [IDX_W-1:0]        r_sched_id;
  logic [DATA_W-1:0]       r_sched_addr;
  logic                    r_spawn_ack;
  logic                    r_spawn_ok;

  logic [MAX_THREADS-1:0]  w_done_mask;
  logic [MAX_THREADS-1:0]  w_sel_valid;
  logic [MAX_THREADS-1:0]  w_promote_mask;
  logic [MAX_THREADS-1:0]  w_valid_next;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_free_found;
  logic [IDX_W-1:0]        w_free_idx;
  logic                    w_rr_found;
  logic [IDX_W-1:0]        w_rr_idx;
  logic [CNT_W-1:0]        w_pend_next;
  logic [CNT_W-1:0]        w_active_next;

  // A slot exiting this cycle is neither selectable nor free for promotion.
  assign w_done_mask = done_vld ? (MAX_THREADS'(1) << done_id) : '0;
  assign w_sel_valid = r_valid & ~w_done_mask;
  assign w_full      = (r_pend_cnt == CNT_W'(MAX_THREADS));
  assign w_push      = spawn_vld & ~w_full;
  assign w_pop       = (r_state == S_PICK) && (r_pend_cnt != '0) && w_free_found;

  assign w_promote_mask = w_pop ? (MAX_THREADS'(1) << w_free_idx) : '0;
  assign w_valid_next   = (r_valid & ~w_done_mask) | w_promote_mask;
  assign w_pend_next    = r_pend_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

  // Lowest-index free slot.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = MAX_THREADS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // Round-robin scan from last+1; the final step wraps back onto last itself.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int i = 1; i <= MAX_THREADS; i++) begin
      if (!w_rr_found && w_sel_valid[r_last + IDX_W'(i)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = r_last + IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_active_next = '0;
    for (int i = 0; i < MAX_THREADS; i++) begin
      w_active_next = w_active_next + CNT_W'(w_valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_fifo[0]    <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= IDX_W'(1);
      r_pend_cnt   <= CNT_W'(1);
      r_active_cnt <= '0;
      r_idle       <= 1'b0;
      r_last       <= IDX_W'(MAX_THREADS - 1);
      r_busy       <= 1'b0;
      r_sched_vld  <= 1'b0;
      r_sched_none <= 1'b0;
      r_sched_id   <= '0;
      r_sched_addr <= '0;
      r_spawn_ack  <= 1'b0;
      r_spawn_ok   <= 1'b0;
    end else begin
      r_valid      <= w_valid_next;
      r_pend_cnt   <= w_pend_next;
      r_active_cnt <= w_active_next;
      r_idle       <= (w_active_next == '0) && (w_pend_next == '0);
      r_spawn_ack  <= spawn_vld;
      r_spawn_ok   <= w_push;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= spawn_addr;
        r_wr_ptr         <= r_wr_ptr + IDX_W'(1);
      end
      if (w_pop) begin
        r_slot_addr[w_free_idx] <= r_fifo[r_rd_ptr];
        r_rd_ptr                <= r_rd_ptr + IDX_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          r_sched_vld <= 1'b0;
          if (sched_req) begin
            r_state <= S_PICK;
            r_busy  <= 1'b1;
          end
        end
        S_PICK: begin
          r_state     <= S_GRANT;
          r_sched_vld <= 1'b1;
          if (w_pop) begin
            r_sched_none <= 1'b0;
            r_sched_id   <= w_free_idx;
            r_sched_addr <= r_fifo[r_rd_ptr];
            r_last       <= w_free_idx;
          end else if (w_rr_found) begin
            r_sched_none <= 1'b0;
            r_sched_id   <= w_rr_idx;
            r_sched_addr <= r_slot_addr[w_rr_idx];
            r_last       <= w_rr_idx;
          end else begin
            r_sched_none <= 1'b1;
            r_sched_id   <= '0;
            r_sched_addr <= '0;
          end
        end
        S_GRANT: begin
          r_state     <= S_IDLE;
          r_sched_vld <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_sched_vld <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign sched_busy = r_busy;
  assign sched_vld  = r_sched_vld;
  assign sched_none = r_sched_none;
  assign sched_id   = r_sched_id;
  assign sched_addr = r_sched_addr;
  assign spawn_ack  = r_spawn_ack;
  assign spawn_ok   = r_spawn_ok;
  assign active_cnt = r_active_cnt;
  assign pend_cnt   = r_pend_cnt;
  assign idle       = r_idle;

`ifdef THRD_SCHED_STATS_EN
  logic [31:0] r_grant_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if ((r_state == S_PICK) && (w_pop || w_rr_found)) begin
        r_grant_cnt <= r_grant_cnt + 32'd1;
      end
      if (spawn_vld && w_full && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign grant_cnt      = r_grant_cnt;
  assign spawn_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed vector bench for thread_scheduler (default parameters: 64-bit addresses, 8 slots).
module tb_thread_scheduler;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sched_req = 1'b0;
  logic              sched_busy, sched_vld, sched_none;
  logic [IDX_W-1:0]  sched_id;
  logic [DATA_W-1:0] sched_addr;
  logic              spawn_vld = 1'b0;
  logic [DATA_W-1:0] spawn_addr = '0;
  logic              spawn_ack, spawn_ok;
  logic              done_vld = 1'b0;
  logic [IDX_W-1:0]  done_id = '0;
  logic [IDX_W:0]    active_cnt, pend_cnt;
  logic              idle;
`ifdef THRD_SCHED_STATS_EN
  logic [31:0]       grant_cnt;
  logic [15:0]       spawn_drop_cnt;
`endif

  thread_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .sched_req  (sched_req),
    .sched_busy (sched_busy),
    .sched_vld  (sched_vld),
    .sched_none (sched_none),
    .sched_id   (sched_id),
    .sched_addr (sched_addr),
    .spawn_vld  (spawn_vld),
    .spawn_addr (spawn_addr),
    .spawn_ack  (spawn_ack),
    .spawn_ok   (spawn_ok),
    .done_vld   (done_vld),
    .done_id    (done_id),
    .active_cnt (active_cnt),
    .pend_cnt   (pend_cnt),
    .idle       (idle)
`ifdef THRD_SCHED_STATS_EN
    ,
    .grant_cnt      (grant_cnt),
    .spawn_drop_cnt (spawn_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst, req, spv;
    logic [DATA_W-1:0] spa;
    logic              dv;
    logic [IDX_W-1:0]  did;
    logic              vld, none;
    logic [IDX_W-1:0]  id;
    logic [DATA_W-1:0] addr;
    logic              busy, ack, ok;
    logic [IDX_W:0]    act, pend;
    logic              idl;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int r, q, sv, sa, dv, di,
                              input int v, n, id, ad, b, ak, ok, ac, pe, il);
    vec_t x;
    x.rst = 1'(r);   x.req = 1'(q);   x.spv = 1'(sv); x.spa  = 64'(sa);
    x.dv  = 1'(dv);  x.did = 3'(di);  x.vld = 1'(v);  x.none = 1'(n);
    x.id  = 3'(id);  x.addr = 64'(ad); x.busy = 1'(b); x.ack = 1'(ak);
    x.ok  = 1'(ok);  x.act = 4'(ac);  x.pend = 4'(pe); x.idl = 1'(il);
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [85:0] got, exp;
    int lat;

    //       rst req spv spa    dv did | vld none id addr  busy ack ok act pend idle
    vq.push_back(mk(1,0,0,0,     0,0,   0,0,0,0,      0,0,0,0,1,0)); // reset state
    vq.push_back(mk(0,1,0,0,     0,0,   0,0,0,0,      1,0,0,0,1,0)); // boot request
    vq.push_back(mk(0,0,0,0,     0,0,   1,0,0,0,      1,0,0,1,0,0)); // boot promoted to slot 0
    vq.push_back(mk(0,0,1,'h100, 0,0,   0,0,0,0,      0,1,1,1,1,0));
    vq.push_back(mk(0,0,1,'h200, 0,0,   0,0,0,0,      0,1,1,1,2,0));
    vq.push_back(mk(0,1,0,0,     0,0,   0,0,0,0,      1,0,0,1,2,0));
    vq.push_back(mk(0,0,0,0,     0,0,   1,0,1,'h100,  1,0,0,2,1,0)); // promote into slot 1
    vq.push_back(mk(0,0,0,0,     0,0,   0,0,1,'h100,  0,0,0,2,1,0));
    vq.push_back(mk(0,1,0,0,     0,0,   0,0,1,'h100,  1,0,0,2,1,0));
    vq.push_back(mk(0,0,0,0,     0,0,   1,0,2,'h200,  1,0,0,3,0,0)); // promote into slot 2
    vq.push_back(mk(0,0,0,0,     0,0,   0,0,2,'h200,  0,0,0,3,0,0));
    vq.push_back(mk(0,1,0,0,     0,0,   0,0,2,'h200,  1,0,0,3,0,0));
    vq.push_back(mk(0,0,0,0,     0,0,   1,0,0,0,      1,0,0,3,0,0)); // round-robin wraps to 0
    vq.push_back(mk(0,0,0,0,     0,0,   0,0,0,0,      0,0,0,3,0,0));
    vq.push_back(mk(0,1,0,0,     0,0,   0,0,0,0,      1,0,0,3,0,0));
    vq.push_back(mk(0,0,0,0,     1,1,   1,0,2,'h200,  1,0,0,2,0,0)); // slot 1 exits during pick
    vq.push_back(mk(0,0,0,0,     0,0,   0,0,2,'h200,  0,0,0,2,0,0));
    vq.push_back(mk(0,0,0,0,     1,0,   0,0,2,'h200,  0,0,0,1,0,0));
    vq.push_back(mk(0,0,0,0,     1,1,   0,0,2,'h200,  0,0,0,1,0,0)); // exit of invalid slot ignored
    vq.push_back(mk(0,0,0,0,     1,2,   0,0,2,'h200,  0,0,0,0,0,1));
    vq.push_back(mk(0,1,0,0,     0,0,   0,0,2,'h200,  1,0,0,0,0,1));
    vq.push_back(mk(0,1,0,0,     0,0,   1,1,0,0,      1,0,0,0,0,1)); // empty grant, req ignored
    vq.push_back(mk(0,1,0,0,     0,0,   0,1,0,0,      0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,     0,0,   0,1,0,0,      0,0,0,0,0,1)); // no second grant
    vq.push_back(mk(1,0,0,0,     0,0,   0,0,0,0,      0,0,0,0,1,0));
    // Boot entry occupies one FIFO place, so only seven spawns fit.
    for (int k = 1; k <= 7; k++)
      vq.push_back(mk(0,0,1,k*'h10, 0,0, 0,0,0,0,     0,1,1,0,k+1,0));
    vq.push_back(mk(0,0,1,'h80,  0,0,   0,0,0,0,      0,1,0,0,8,0));
    vq.push_back(mk(0,0,1,'h90,  0,0,   0,0,0,0,      0,1,0,0,8,0));
    vq.push_back(mk(0,0,0,0,     0,0,   0,0,0,0,      0,0,0,0,8,0));
    vq.push_back(mk(0,1,0,0,     0,0,   0,0,0,0,      1,0,0,0,8,0));
    vq.push_back(mk(0,0,1,'h999, 0,0,   1,0,0,0,      1,1,0,1,7,0)); // full: rejected despite pop
    vq.push_back(mk(0,0,1,'haaa, 0,0,   0,0,0,0,      0,1,1,1,8,0));
    vq.push_back(mk(0,1,0,0,     0,0,   0,0,0,0,      1,0,0,1,8,0));
    vq.push_back(mk(0,0,0,0,     0,0,   1,0,1,'h10,   1,0,0,2,7,0));
    vq.push_back(mk(0,0,0,0,     0,0,   0,0,1,'h10,   0,0,0,2,7,0));
    vq.push_back(mk(0,1,0,0,     0,0,   0,0,1,'h10,   1,0,0,2,7,0));
    vq.push_back(mk(0,0,1,'hbbb, 0,0,   1,0,2,'h20,   1,1,1,3,7,0)); // push and pop together
    vq.push_back(mk(0,0,0,0,     0,0,   0,0,2,'h20,   0,0,0,3,7,0));

    foreach (vq[k]) begin
      rst = vq[k].rst; sched_req = vq[k].req; spawn_vld = vq[k].spv;
      spawn_addr = vq[k].spa; done_vld = vq[k].dv; done_id = vq[k].did;
      tick();
      got = {sched_vld, sched_none, sched_id, sched_addr, sched_busy, spawn_ack,
             spawn_ok, active_cnt, pend_cnt, idle};
      exp = {vq[k].vld, vq[k].none, vq[k].id, vq[k].addr, vq[k].busy, vq[k].ack,
             vq[k].ok, vq[k].act, vq[k].pend, vq[k].idl};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL vec%0d: got vld=%b none=%b id=%0d addr=%0h busy=%b ack=%b ok=%b act=%0d pend=%0d idle=%b expected vld=%b none=%b id=%0d addr=%0h busy=%b ack=%b ok=%b act=%0d pend=%0d idle=%b",
                 k, sched_vld, sched_none, sched_id, sched_addr, sched_busy, spawn_ack, spawn_ok,
                 active_cnt, pend_cnt, idle, vq[k].vld, vq[k].none, vq[k].id, vq[k].addr,
                 vq[k].busy, vq[k].ack, vq[k].ok, vq[k].act, vq[k].pend, vq[k].idl);
      end
    end
    sched_req = 1'b0; spawn_vld = 1'b0; done_vld = 1'b0;

`ifdef THRD_SCHED_STATS_EN
    check("grant_cnt", 64'(grant_cnt), 64'd3);
    check("spawn_drop_cnt", 64'(spawn_drop_cnt), 64'd3);
`endif

    // Grant latency after reset, bounded wait.
    rst = 1'b1; tick();
    rst = 1'b0; sched_req = 1'b1; tick();
    sched_req = 1'b0;
    lat = 1;
    while (!sched_vld && lat < 6) begin
      tick();
      lat++;
    end
    check("grant_latency", 64'(lat), 64'd2);
    check("boot_grant_id", 64'(sched_id), 64'd0);
    tick();

    // Reset while a request is in pick, with a spawn sampled on the reset edge.
    sched_req = 1'b1; tick();
    sched_req = 1'b0;
    check("abort_in_pick", 64'(sched_busy), 64'd1);
    rst = 1'b1; spawn_vld = 1'b1; spawn_addr = 64'h55; tick();
    check("abort_rst_outputs", 64'({sched_vld, sched_busy, spawn_ack, pend_cnt}), 64'(4'd1));
    rst = 1'b0; spawn_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("abort_no_strobe", 64'({sched_vld, spawn_ack, sched_busy}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
